// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer and a saturating count of flush-discarded entries.
module pipe_stage_reg #(
   parameter int DATA_W        = 32,
   parameter int SKID          = 1,
   parameter int ZERO_ON_FLUSH = 1,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        count,
   output logic [CNT_W-1:0]  flush_drops
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_main;
   logic [DATA_W-1:0]   r_skid;
   logic [DATA_W-1:0]   w_main_nxt;
   logic [DATA_W-1:0]   w_skid_nxt;
   logic                r_in_ready;
   logic [CNT_W-1:0]    r_drops;
   logic [CNT_W-1:0]    w_drops_nxt;
   logic                w_in_fire;
   logic                w_out_fire;
   logic [1:0]          w_drop_inc;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
      logic [CNT_W+1:0] s;
      s = {2'b00, a} + {{CNT_W{1'b0}}, b};
      if (s > {2'b00, {CNT_W{1'b1}}})
         return {CNT_W{1'b1}};
      return s[CNT_W-1:0];
   endfunction

   assign out_valid   = (r_state != S_EMPTY);
   assign out_data    = r_main;
   assign flush_drops = r_drops;
   assign count       = (r_state == S_TWO) ? 2'd2 :
                        (r_state == S_ONE) ? 2'd1 : 2'd0;

   // With the skid buffer, upstream ready is a flop and never sees out_ready.
   assign in_ready   = (SKID != 0) ? r_in_ready : (!out_valid | out_ready);
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   // Entries lost to a flush: held ones not delivered this edge, plus any arrival.
   assign w_drop_inc = count - {1'b0, w_out_fire} + {1'b0, w_in_fire};

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      w_drops_nxt = r_drops;
      if (flush) begin
         w_state_nxt = S_EMPTY;
         w_drops_nxt = sat_add(r_drops, w_drop_inc);
         if (ZERO_ON_FLUSH != 0) begin
            w_main_nxt = '0;
            w_skid_nxt = '0;
         end
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_in_fire) begin
                  w_main_nxt  = in_data;
                  w_state_nxt = S_ONE;
               end
            end
            S_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_main_nxt = in_data;
               end else if (w_in_fire && (SKID != 0)) begin
                  w_skid_nxt  = in_data;
                  w_state_nxt = S_TWO;
               end else if (w_out_fire) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               if (w_out_fire) begin
                  w_main_nxt  = r_skid;
                  w_state_nxt = S_ONE;
               end
            end
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_EMPTY;
         r_main     <= '0;
         r_skid     <= '0;
         r_drops    <= '0;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_main     <= w_main_nxt;
         r_skid     <= w_skid_nxt;
         r_drops    <= w_drops_nxt;
         r_in_ready <= (w_state_nxt != S_TWO);
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a skid/zeroing/narrow-counter instance and a
// no-skid/holding instance, each checked against a queue-based occupancy model.
module tb_pipe_stage_reg;

   localparam int DW = 32;

   logic           clk = 1'b0;
   logic           reset;
   logic           flush     [2];
   logic           in_valid  [2];
   logic           in_ready  [2];
   logic [DW-1:0]  in_data   [2];
   logic           out_valid [2];
   logic           out_ready [2];
   logic [DW-1:0]  out_data  [2];
   logic [1:0]     count     [2];
   logic [1:0]     drops_a;
   logic [15:0]    drops_b;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(DW), .SKID(1), .ZERO_ON_FLUSH(1), .CNT_W(2)) u_skid (
      .clk(clk), .reset(reset), .flush(flush[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .count(count[0]), .flush_drops(drops_a)
   );

   pipe_stage_reg #(.DATA_W(DW), .SKID(0), .ZERO_ON_FLUSH(0), .CNT_W(16)) u_noskid (
      .clk(clk), .reset(reset), .flush(flush[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .count(count[1]), .flush_drops(drops_b)
   );

   // Model: exp_q holds the accepted, not yet delivered entries of each instance.
   logic [DW-1:0]  exp_q [2][$];
   int             model_drops [2];
   int             drop_cap    [2];
   logic           pred_ir     [2];
   logic           zeroed;
   logic           rst_seen;

   logic           nxt_iv   [2];
   logic [DW-1:0]  nxt_data [2];
   logic           nxt_ordy [2];
   logic           nxt_fl   [2];
   logic           nxt_rst;

   int checks;
   int errors;

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual=%h required=%h t=%0t", nm, idx, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] get_drops(input int idx);
      if (idx == 0) return {30'd0, drops_a};
      return {16'd0, drops_b};
   endfunction

   task automatic cycle();
      logic fire;
      int   nd;
      reset = nxt_rst;
      for (int i = 0; i < 2; i++) begin
         flush[i]     = nxt_fl[i];
         in_valid[i]  = nxt_iv[i];
         in_data[i]   = nxt_data[i];
         out_ready[i] = nxt_ordy[i];
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) pred_ir[i] = (exp_q[i].size() < 2);
         else        pred_ir[i] = (exp_q[i].size() == 0) || out_ready[i];
         if (rst_seen && !nxt_rst) chk("in_ready", i, {31'd0, in_ready[i]}, {31'd0, pred_ir[i]});
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         fire = in_valid[i] & pred_ir[i];
         if (reset) begin
            exp_q[i].delete();
            model_drops[i] = 0;
            if (i == 0) zeroed = 1'b1;
         end else if (flush[i]) begin
            nd = model_drops[i] + exp_q[i].size() + (fire ? 1 : 0);
            model_drops[i] = (nd > drop_cap[i]) ? drop_cap[i] : nd;
            exp_q[i].delete();
            if (i == 0) zeroed = 1'b1;
         end else if (fire) begin
            exp_q[i].push_back(in_data[i]);
            if (i == 0) zeroed = 1'b0;
         end
      end
      if (reset) rst_seen = 1'b1;
      if (rst_seen) begin
         for (int i = 0; i < 2; i++) begin
            chk("out_valid", i, {31'd0, out_valid[i]}, {31'd0, (exp_q[i].size() != 0)});
            chk("count", i, {30'd0, count[i]}, exp_q[i].size());
            chk("flush_drops", i, get_drops(i), model_drops[i]);
         end
         if (zeroed && exp_q[0].size() == 0) chk("zeroed_data", 0, out_data[0], 32'd0);
      end
   endtask

   task automatic drive_both(input logic iv, input logic [DW-1:0] d, input logic ordy,
                             input logic fl);
      for (int i = 0; i < 2; i++) begin
         nxt_iv[i]   = iv;
         nxt_data[i] = d;
         nxt_ordy[i] = ordy;
         nxt_fl[i]   = fl;
      end
      cycle();
   endtask

   // Monitor: every delivery must match the oldest outstanding accepted entry.
   always @(negedge clk) begin
      if (rst_seen && !reset) begin
         for (int i = 0; i < 2; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               if (exp_q[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL deliver dut%0d actual=%h required=<no entry>", i, out_data[i]);
               end else begin
                  chk("out_data", i, out_data[i], exp_q[i].pop_front());
               end
            end
         end
      end
   end

   initial begin
      int bias;
      checks = 0;
      errors = 0;
      rst_seen = 1'b0;
      zeroed = 1'b1;
      drop_cap[0] = 3;
      drop_cap[1] = 65535;
      model_drops[0] = 0;
      model_drops[1] = 0;

      nxt_rst = 1'b1;
      drive_both(1'b0, '0, 1'b1, 1'b0);
      drive_both(1'b0, '0, 1'b1, 1'b0);
      nxt_rst = 1'b0;

      for (int k = 0; k < 8; k++) drive_both(1'b1, 32'h100 + k, 1'b1, 1'b0);
      drive_both(1'b0, '0, 1'b1, 1'b0);

      drive_both(1'b1, 32'hA, 1'b0, 1'b0);
      drive_both(1'b1, 32'hB, 1'b0, 1'b0);
      drive_both(1'b1, 32'hC, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) drive_both(1'b0, '0, 1'b1, 1'b0);

      drive_both(1'b1, 32'hA, 1'b0, 1'b0);
      drive_both(1'b1, 32'hB, 1'b0, 1'b0);
      drive_both(1'b1, 32'hD, 1'b0, 1'b1);
      drive_both(1'b0, '0, 1'b1, 1'b0);
      drive_both(1'b0, '0, 1'b1, 1'b0);

      drive_both(1'b1, 32'h11, 1'b1, 1'b0);
      drive_both(1'b0, '0, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         drive_both(1'b1, 32'h20 + k, 1'b0, 1'b0);
         drive_both(1'b0, '0, 1'b0, 1'b1);
      end

      bias = 3;
      for (int n = 0; n < 3000; n++) begin
         if (n % 40 == 0) bias = $urandom_range(0, 3);
         for (int i = 0; i < 2; i++) begin
            nxt_iv[i]   = ($urandom_range(0, 3) != 0);
            nxt_data[i] = $urandom;
            nxt_ordy[i] = ($urandom_range(0, 3) <= bias);
            nxt_fl[i]   = ($urandom_range(0, 19) == 0);
         end
         nxt_rst = ($urandom_range(0, 399) == 0);
         cycle();
      end
      nxt_rst = 1'b0;

      for (int k = 0; k < 3; k++) drive_both(1'b1, 32'h300 + k, 1'b0, 1'b0);
      drive_both(1'b0, '0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) drive_both(1'b1, 32'h310 + k, 1'b1, 1'b0);
      nxt_rst = 1'b1;
      drive_both(1'b1, 32'h320, 1'b1, 1'b0);
      nxt_rst = 1'b0;
      drive_both(1'b0, '0, 1'b1, 1'b0);
      drive_both(1'b1, 32'h330, 1'b1, 1'b0);
      drive_both(1'b0, '0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register carrying an arbitrary-width payload between CPU pipeline stages. It has a valid/ready handshake, a synchronous flush that kills in-flight entries, and an optional 2-entry skid buffer so the upstream ready is fully registered. A saturating counter reports how many valid entries flushes have discarded. It replaces the fixed-field stage registers (F/D, D/E, E/M, M/W) with one reusable block.

Parameters:
DATA_W, 32, payload width in bits (callers concatenate control and data fields)
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
ZERO_ON_FLUSH, 1, 1 = payload registers cleared to 0 on flush; 0 = payload held and only valid cleared
CNT_W, 16, width of the flush-drop counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of all held entries (branch/exception redirect)
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_data  input  DATA_W  upstream payload
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream accepts this cycle
out_data  output  DATA_W  payload of head entry
count  output  2  entries held (0..2; max 1 when SKID=0)
flush_drops  output  CNT_W  saturating count of valid entries discarded by flush

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (head, drives out_data) plus skid register (SKID=1 only).
- Reset (clk edge with reset=1): state EMPTY, out_valid=0, count=0, main/skid payload=0, flush_drops=0; in_ready=1 in the cycle after reset.
- Priority per edge: reset > flush > normal transfer.
- States (SKID=1):
  - EMPTY: count=0, out_valid=0, in_ready=1. in_fire -> main<=in_data, go ONE.
  - ONE: count=1, out_valid=1, in_ready=1.
    - in_fire & out_fire -> main<=in_data, stay ONE.
    - in_fire & !out_fire -> skid<=in_data, go TWO.
    - !in_fire & out_fire -> go EMPTY.
    - Neither -> hold.
  - TWO: count=2, out_valid=1, in_ready=0. out_fire -> main<=skid, go ONE; otherwise hold.
- in_ready when SKID=1 is a flop output equal to (next state != TWO). It never depends combinationally on out_ready.
- SKID=0: only EMPTY/ONE exist; in_ready = !out_valid | out_ready (combinational). ONE with in_fire & out_fire replaces main; ONE with !in_fire & out_fire goes EMPTY.
- Latency: an entry accepted at edge N is visible on out_valid/out_data after edge N (1 cycle). Back-to-back throughput is 1 entry/cycle when out_ready stays high.
- out_data while out_valid=0: the value of the last held payload (0 after reset or after a flush with ZERO_ON_FLUSH=1). Consumers must not sample it.
- Flush at an edge:
  - Next state EMPTY, count=0, out_valid=0.
  - Any same-cycle in_fire entry is discarded and is not stored.
  - An out_fire in the same cycle still counts as delivered, because downstream sampled it.
  - flush_drops += (number of held valid entries) − (1 if out_fire) + (1 if in_fire), saturating at 2^CNT_W−1 with no wrap.
  - Payload registers are zeroed iff ZERO_ON_FLUSH=1.
- Payload stability: out_data must not change while out_valid=1 & out_ready=0, except on flush or reset.
- Reset mid-operation: all entries are lost silently; flush_drops is cleared, not incremented.
- Illegal conditions: none; in_valid while in_ready=0 is ignored (upstream holds).

Test Plan:
- Reset, then stream in_data=0x100..0x107 with out_ready=1 -> out_data 0x100..0x107 on consecutive cycles, each 1 cycle after acceptance, count=1 steady, no bubbles.
- SKID=1: accept 0xA, then 0xB with out_ready=0 -> count=2, in_ready=0 next cycle. Raise out_ready -> 0xA then 0xB delivered in order, in_ready=1 one cycle after 0xA leaves.
- SKID=1 in TWO with out_ready=0, flush=1, in_valid=1 -> count=0, out_valid=0, payload=0, flush_drops=2. Incoming entry not delivered later.
- Flush with count=1 and out_fire in the same cycle -> entry counted as delivered, flush_drops unchanged. Flush with count=1 and out_ready=0 -> flush_drops +1.
- CNT_W=2: apply 5 flushes each dropping 1 entry -> flush_drops reads 1,2,3,3,3 (saturates).
- SKID=0: out_ready held 0 with in_valid=1 -> in_ready=0 while full. Set out_ready=1 -> in_ready=1 the same cycle, replacement completes in one edge. Assert reset mid-stream -> out_valid=0, count=0, flush_drops=0 next cycle.
